// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: CR16-style opcode encodings, flag indices, FSM/op types and per-op flag masks.
package alu_pkg;

  localparam logic [3:0] OP_RR     = 4'b0000;
  localparam logic [3:0] OP_ADDI   = 4'b0101;
  localparam logic [3:0] OP_ADDUI  = 4'b0110;
  localparam logic [3:0] OP_ADDCI  = 4'b0111;
  localparam logic [3:0] OP_LSH    = 4'b1000;
  localparam logic [3:0] OP_SUBI   = 4'b1001;
  localparam logic [3:0] OP_ADDCU  = 4'b1010;
  localparam logic [3:0] OP_CMPI   = 4'b1011;

  localparam logic [3:0] EXT_AND    = 4'b0001;
  localparam logic [3:0] EXT_OR     = 4'b0010;
  localparam logic [3:0] EXT_XOR    = 4'b0011;
  localparam logic [3:0] EXT_LSH    = 4'b0100;
  localparam logic [3:0] EXT_ADD    = 4'b0101;
  localparam logic [3:0] EXT_ADDU   = 4'b0110;
  localparam logic [3:0] EXT_ADDC   = 4'b0111;
  localparam logic [3:0] EXT_SUB    = 4'b1001;
  localparam logic [3:0] EXT_CMP    = 4'b1011;
  localparam logic [3:0] EXT_MUL    = 4'b1110;
  localparam logic [3:0] EXT_ADDCU  = 4'b0101;
  localparam logic [3:0] EXT_ADDCUI = 4'b0110;

  localparam int FLG_C = 4;
  localparam int FLG_L = 3;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 0;

  localparam logic [4:0] MASK_ADD   = 5'b00110;
  localparam logic [4:0] MASK_ADDU  = 5'b10010;
  localparam logic [4:0] MASK_ADDC  = 5'b10110;
  localparam logic [4:0] MASK_ADDCU = 5'b10010;
  localparam logic [4:0] MASK_SUB   = 5'b10110;
  localparam logic [4:0] MASK_CMP   = 5'b01011;
  localparam logic [4:0] MASK_MUL   = 5'b00010;
  localparam logic [4:0] MASK_LSH   = 5'b10000;
  localparam logic [4:0] MASK_NONE  = 5'b00000;

  typedef enum logic [1:0] {IDLE, MUL, SHIFT, DONE} state_e;

  typedef enum logic [3:0] {
    A_ADD, A_ADDU, A_ADDC, A_ADDCU, A_SUB, A_CMP,
    A_AND, A_OR, A_XOR, A_MUL, A_LSH, A_ILL
  } alu_op_e;

  function automatic alu_op_e decode_op(input logic [3:0] opcode, input logic [3:0] opext,
                                        input logic mul_en);
    alu_op_e op;
    op = A_ILL;
    case (opcode)
      OP_RR: begin
        case (opext)
          EXT_AND:  op = A_AND;
          EXT_OR:   op = A_OR;
          EXT_XOR:  op = A_XOR;
          EXT_ADD:  op = A_ADD;
          EXT_ADDU: op = A_ADDU;
          EXT_ADDC: op = A_ADDC;
          EXT_SUB:  op = A_SUB;
          EXT_CMP:  op = A_CMP;
          EXT_MUL:  op = mul_en ? A_MUL : A_ILL;
          default:  op = A_ILL;
        endcase
      end
      OP_ADDI:  op = A_ADD;
      OP_ADDUI: op = A_ADDU;
      OP_ADDCI: op = A_ADDC;
      OP_SUBI:  op = A_SUB;
      OP_CMPI:  op = A_CMP;
      OP_ADDCU: op = (opext == EXT_ADDCU || opext == EXT_ADDCUI) ? A_ADDCU : A_ILL;
      OP_LSH:   op = (opext == EXT_LSH) ? A_LSH : A_ILL;
      default:  op = A_ILL;
    endcase
    return op;
  endfunction

  function automatic logic [4:0] flag_mask(input alu_op_e op);
    logic [4:0] m;
    case (op)
      A_ADD:   m = MASK_ADD;
      A_ADDU:  m = MASK_ADDU;
      A_ADDC:  m = MASK_ADDC;
      A_ADDCU: m = MASK_ADDCU;
      A_SUB:   m = MASK_SUB;
      A_CMP:   m = MASK_CMP;
      A_MUL:   m = MASK_MUL;
      A_LSH:   m = MASK_LSH;
      default: m = MASK_NONE;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_core.sv
`default_nettype none
// alu_seq_core: combinational single-cycle datapath (add/sub/logic/compare) with raw flag values.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flg,
  output logic             wr_en,
  output logic             illegal
);

  logic             use_cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  assign use_cin = (op == A_ADDC) || (op == A_ADDCU);
  assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, use_cin & cin};
  assign diff    = {1'b0, a} - {1'b0, b};

  always_comb begin
    result  = '0;
    flg     = '0;
    wr_en   = 1'b1;
    illegal = 1'b0;
    case (op)
      A_ADD, A_ADDU, A_ADDC, A_ADDCU: begin
        result     = sum[WIDTH-1:0];
        flg[FLG_C] = sum[WIDTH];
        flg[FLG_F] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        flg[FLG_Z] = ~|sum[WIDTH-1:0];
      end
      A_SUB: begin
        result     = diff[WIDTH-1:0];
        flg[FLG_C] = diff[WIDTH];
        flg[FLG_F] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        flg[FLG_Z] = ~|diff[WIDTH-1:0];
      end
      A_CMP: begin
        wr_en      = 1'b0;
        flg[FLG_Z] = (a == b);
        flg[FLG_N] = $signed(b) > $signed(a);
        flg[FLG_L] = b > a;
      end
      A_AND: result = a & b;
      A_OR:  result = a | b;
      A_XOR: result = a ^ b;
      // Multi-cycle ops are produced by the sequencer; nothing to do here.
      A_MUL, A_LSH: ;
      default: begin
        wr_en   = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// alu_seq: registered CR16-style ALU with start/done handshake, internal CLFZN flags,
// shift-add multiplier and bit-serial logical shifter.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter bit MUL_EN  = 1'b1,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [3:0]       opext,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic             illegal,
  output logic [4:0]       flags
);

  localparam int CNT_W = (SHAMT_W > $clog2(WIDTH + 1)) ? SHAMT_W : $clog2(WIDTH + 1);

  state_e           state, state_nx;
  alu_op_e          op;
  logic [WIDTH-1:0] core_res;
  logic [4:0]       core_flg, core_mask;
  logic             core_wr, core_ill;

  logic [WIDTH-1:0] acc, mcand, mplier, result_q;
  logic [CNT_W-1:0] cnt, amt_cnt;
  logic [4:0]       flags_q;
  logic             shl, wr_q, ill_q, last;
  logic [WIDTH-1:0] mul_nx, sh_nx;
  logic             sh_out;

  logic [SHAMT_W-1:0] shamt, amt_mag;
  logic               amt_neg;

  assign op        = decode_op(opcode, opext, MUL_EN);
  assign core_mask = flag_mask(op);

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .op      (op),
    .a       (a),
    .b       (b),
    .cin     (flags_q[FLG_C]),
    .result  (core_res),
    .flg     (core_flg),
    .wr_en   (core_wr),
    .illegal (core_ill)
  );

  // Shift count is the magnitude of the signed field, clamped to WIDTH steps.
  assign shamt   = b[SHAMT_W-1:0];
  assign amt_neg = shamt[SHAMT_W-1];
  assign amt_mag = amt_neg ? (~shamt + SHAMT_W'(1)) : shamt;
  assign amt_cnt = (CNT_W'(amt_mag) >= CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(amt_mag);

  assign last   = (cnt == CNT_W'(1));
  assign mul_nx = mplier[0] ? (acc + mcand) : acc;
  assign sh_nx  = shl ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};
  assign sh_out = shl ? acc[WIDTH-1] : acc[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          case (op)
            A_MUL:   state_nx = MUL;
            A_LSH:   state_nx = (amt_cnt == '0) ? DONE : SHIFT;
            default: state_nx = DONE;
          endcase
        end
      end
      MUL:     if (last) state_nx = DONE;
      SHIFT:   if (last) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      shl      <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      wr_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          case (op)
            A_MUL: begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= CNT_W'(WIDTH);
            end
            A_LSH: begin
              acc <= a;
              shl <= ~amt_neg;
              cnt <= amt_cnt;
              if (amt_cnt == '0) begin
                result_q       <= a;
                flags_q[FLG_C] <= 1'b0;
                wr_q           <= 1'b1;
                ill_q          <= 1'b0;
              end
            end
            default: begin
              if (core_ill)     result_q <= '0;
              else if (core_wr) result_q <= core_res;
              flags_q <= (flags_q & ~core_mask) | (core_flg & core_mask);
              wr_q    <= core_wr;
              ill_q   <= core_ill;
            end
          endcase
        end
        MUL: begin
          acc    <= mul_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (last) begin
            result_q       <= mul_nx;
            flags_q[FLG_Z] <= ~|mul_nx;
            wr_q           <= 1'b1;
            ill_q          <= 1'b0;
          end
        end
        SHIFT: begin
          acc <= sh_nx;
          cnt <= cnt - CNT_W'(1);
          if (last) begin
            result_q       <= sh_nx;
            flags_q[FLG_C] <= sh_out;
            wr_q           <= 1'b1;
            ill_q          <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result  = result_q;
  assign flags   = flags_q;
  assign wr_en   = wr_q & done;
  assign illegal = ill_q & done;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// tb_alu_seq: scoreboard bench; an arithmetic reference model predicts each done pulse.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [3:0]  opext = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, wr_en, illegal;
  logic [15:0] result;
  logic [4:0]  flags;

  alu_seq #(.WIDTH(16), .MUL_EN(1'b1), .SHAMT_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .opcode  (opcode),
    .opext   (opext),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .wr_en   (wr_en),
    .illegal (illegal),
    .flags   (flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] res;
    logic        wr;
    logic        ill;
    logic [4:0]  flg;
    int          when;
  } exp_t;
  exp_t sbq[$];

  typedef enum {K_ADD, K_ADDU, K_ADDC, K_ADDCU, K_SUB, K_CMP, K_AND, K_OR, K_XOR,
                K_MUL, K_LSH, K_ILL} kind_e;

  // Architectural state as seen by software: last written result and the five flags.
  logic [15:0] m_result = '0;
  logic mC = 0, mL = 0, mF = 0, mZ = 0, mN = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model(input logic [3:0] opc, input logic [3:0] ext, input logic [15:0] av,
                       input logic [15:0] bv, input int now, output exp_t e);
    kind_e  k;
    longint ua, ub, sa, sb, s, ss;
    int     amt, n, lat;
    logic   wr, ill;
    ua = longint'(av); ub = longint'(bv);
    sa = longint'($signed(av)); sb = longint'($signed(bv));
    lat = 1; wr = 1'b1; ill = 1'b0;
    casez ({opc, ext})
      8'b0000_0101, 8'b0101_????: k = K_ADD;
      8'b0000_0110, 8'b0110_????: k = K_ADDU;
      8'b0000_0111, 8'b0111_????: k = K_ADDC;
      8'b1010_0101, 8'b1010_0110: k = K_ADDCU;
      8'b0000_1001, 8'b1001_????: k = K_SUB;
      8'b0000_1011, 8'b1011_????: k = K_CMP;
      8'b0000_0001:               k = K_AND;
      8'b0000_0010:               k = K_OR;
      8'b0000_0011:               k = K_XOR;
      8'b0000_1110:               k = K_MUL;
      8'b1000_0100:               k = K_LSH;
      default:                    k = K_ILL;
    endcase
    case (k)
      K_ADD: begin
        s = ua + ub; ss = sa + sb;
        m_result = s[15:0]; mF = (ss > 32767) || (ss < -32768); mZ = (m_result == 0);
      end
      K_ADDU: begin
        s = ua + ub; m_result = s[15:0]; mC = (s > 65535); mZ = (m_result == 0);
      end
      K_ADDC: begin
        s = ua + ub + longint'(mC); ss = sa + sb + longint'(mC);
        m_result = s[15:0]; mC = (s > 65535); mF = (ss > 32767) || (ss < -32768);
        mZ = (m_result == 0);
      end
      K_ADDCU: begin
        s = ua + ub + longint'(mC);
        m_result = s[15:0]; mC = (s > 65535); mZ = (m_result == 0);
      end
      K_SUB: begin
        s = ua - ub; ss = sa - sb;
        m_result = s[15:0]; mC = (ua < ub); mF = (ss > 32767) || (ss < -32768);
        mZ = (m_result == 0);
      end
      K_CMP: begin
        wr = 1'b0; mZ = (ua == ub); mN = (sb > sa); mL = (ub > ua);
      end
      K_AND: m_result = av & bv;
      K_OR:  m_result = av | bv;
      K_XOR: m_result = av ^ bv;
      K_MUL: begin
        s = ua * ub; m_result = s[15:0]; mZ = (m_result == 0); lat = 17;
      end
      K_LSH: begin
        amt = int'(bv[4:0]);
        if (amt > 15) amt -= 32;
        if (amt == 0) begin
          m_result = av; mC = 1'b0;
        end else if (amt > 0) begin
          s = ua << amt; m_result = s[15:0]; mC = av[16-amt]; lat = amt + 1;
        end else begin
          n = -amt; m_result = av >> n; mC = av[n-1]; lat = n + 1;
        end
      end
      default: begin
        m_result = '0; wr = 1'b0; ill = 1'b1;
      end
    endcase
    e.res = m_result; e.wr = wr; e.ill = ill;
    e.flg = {mC, mL, mF, mZ, mN}; e.when = now + lat;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy !== 1'b0 || done !== 1'b0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: actual busy=%b done=%b required both 0", busy, done);
    end
  endtask

  task automatic issue(input logic [3:0] opc, input logic [3:0] ext, input logic [15:0] av,
                       input logic [15:0] bv);
    exp_t e;
    @(negedge clk);
    wait_idle();
    opcode = opc; opext = ext; a = av; b = bv; start = 1'b1;
    model(opc, ext, av, bv, cyc, e);
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); opcode = 4'($urandom); opext = 4'($urandom);
  endtask

  // Start pulse with no expectation: used where the DUT must ignore or abort it.
  task automatic pulse(input logic [3:0] opc, input logic [3:0] ext, input logic [15:0] av,
                       input logic [15:0] bv);
    @(negedge clk);
    opcode = opc; opext = ext; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [15:0] rand_operand();
    logic [15:0] corners [5];
    corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && done === 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: actual done=1 required no pending op (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          check("latency", cyc, e.when);
          check("result", result, e.res);
          check("wr_en", wr_en, e.wr);
          check("illegal", illegal, e.ill);
          check("flags", flags, e.flg);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] rr_ops [12];
    logic [3:0] imm_ops [5];
    logic [7:0] pick;
    int g;
    rr_ops  = '{8'h05, 8'h06, 8'h07, 8'hA5, 8'hA6, 8'h09, 8'h0B, 8'h01, 8'h02, 8'h03, 8'h0E, 8'h84};
    imm_ops = '{4'h5, 4'h6, 4'h7, 4'h9, 4'hB};

    repeat (2) @(negedge clk);
    check("rst_result", result, 16'h0);
    check("rst_flags", flags, 5'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    reset_n = 1'b1;

    // Abort a MUL mid-flight; no done may follow.
    pulse(4'b0000, 4'b1110, 16'd3, 16'd5);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_flags", flags, 5'h0);
    @(negedge clk);
    reset_n = 1'b1;
    m_result = '0; {mC, mL, mF, mZ, mN} = 5'b0;

    issue(4'b0000, 4'b0101, 16'd1, 16'd1);
    issue(4'b0000, 4'b0110, 16'hFFFF, 16'h0001);
    issue(4'b0000, 4'b0111, 16'h0001, 16'h0001);
    issue(4'b0000, 4'b0101, 16'h7FFF, 16'h0001);
    issue(4'b0000, 4'b0001, 16'hF0F0, 16'h3C3C);
    issue(4'b0000, 4'b1011, 16'd5, 16'd7);

    // MUL with a start during busy that must be dropped.
    issue(4'b0000, 4'b1110, 16'h00FF, 16'h0101);
    repeat (2) @(negedge clk);
    pulse(4'b0000, 4'b0101, 16'h1234, 16'h1111);

    issue(4'b1000, 4'b0100, 16'h8001, 16'h0001);
    issue(4'b1000, 4'b0100, 16'h8001, 16'hFFFF);
    issue(4'b1000, 4'b0100, 16'h8001, 16'h0000);
    issue(4'b1111, 4'b1111, 16'h1234, 16'h5678);

    // Start during the DONE cycle must be dropped.
    issue(4'b0000, 4'b0011, 16'hAAAA, 16'h5555);
    opcode = 4'b0000; opext = 4'b0101; a = 16'h0100; b = 16'h0200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    issue(4'b1000, 4'b0100, 16'hC3A5, 16'h0010);
    issue(4'b1000, 4'b0100, 16'hC3A5, 16'h000F);

    repeat (200) begin
      case ($urandom_range(0, 3))
        0: pick = rr_ops[$urandom_range(0, 11)];
        1: pick = {imm_ops[$urandom_range(0, 4)], 4'($urandom)};
        2: pick = 8'h84;
        default: pick = 8'($urandom);
      endcase
      issue(pick[7:4], pick[3:0], rand_operand(), rand_operand());
    end

    g = 0;
    while (sbq.size() > 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    while (sbq.size() > 0) begin
      void'(sbq.pop_front());
      n_cmp++; n_err++;
      $display("FAIL missing_done: actual no done required one pending op");
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
